mine_placer: RTL and testbench

//  Upstream stage of the mine Board / adjacency Board pair. On start, places numMines mines at

---
 rtl/minesweeper_pkg.sv | 16 +
 rtl/mine_placer_lfsr.sv | 29 ++
 rtl/mine_placer.sv | 122 ++++++++++++
 tb/tb_mine_placer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/minesweeper_pkg.sv
// Shared constants and state encoding for the minesweeper board pipeline.
// Imported by the mine placer and its LFSR.
package minesweeper_pkg;

  localparam logic [15:0] LFSR_MASK    = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

  typedef enum logic [2:0] {
    IDLE,
    GEN,
    CHECK,
    PLACE,
    DONE
  } placerState_t;

endpackage

// File: rtl/mine_placer_lfsr.sv
// 16-bit Galois LFSR feeding candidate mine coordinates.
// A zero load value would lock the register, so it falls back to the default.
module lfsr16
  import minesweeper_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] loadValue,
  input  logic        step,
  output logic [15:0] value
);

  logic [15:0] shifted;

  assign shifted = {1'b0, value[15:1]}
                 ^ (value[0] ? LFSR_MASK : 16'h0000);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= LFSR_DEFAULT;
    end else if (load) begin
      value <= (loadValue == 16'h0000) ? LFSR_DEFAULT : loadValue;
    end else if (step) begin
      value <= shifted;
    end
  end

endmodule

// File: rtl/mine_placer.sv
// Places distinct pseudo-random mines, avoiding the first-click cell.
// Duplicates are caught by reading the mine board back before writing.
module mine_placer
  import minesweeper_pkg::*;
#(
  parameter  int width  = 8,
  parameter  int height = 8,
  localparam int XW     = $clog2(width),
  localparam int YW     = $clog2(height),
  localparam int CW     = $clog2(width * height + 1)
) (
  input  logic          clk_tb,
  input  logic          reset_tb,
  input  logic          start,
  input  logic [15:0]   seed,
  input  logic [CW-1:0] numMines,
  input  logic [XW-1:0] safeX,
  input  logic [YW-1:0] safeY,
  output logic [XW-1:0] readX,
  output logic [YW-1:0] readY,
  input  logic          mineReadValue,
  output logic [XW-1:0] placeX,
  output logic [YW-1:0] placeY,
  output logic          placeEn,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] placedCount
);

  localparam int CELLS = width * height;
  localparam logic [CW-1:0] MAX_MINES = CW'(CELLS - 1);
  localparam logic [XW:0] WIDTH_LIM = (XW + 1)'(width);
  localparam logic [YW:0] HEIGHT_LIM = (YW + 1)'(height);

  placerState_t state, stateNext;

  logic [15:0]   lfsrValue;
  logic          unusedLfsr;
  logic [XW-1:0] lfsrX, candX, safeXq;
  logic [YW-1:0] lfsrY, candY, safeYq;
  logic [CW-1:0] target, numMinesClamp;
  logic          accept, reject, lastPlace;

  lfsr16 uLfsr (
    .clk       (clk_tb),
    .rst_n     (reset_tb),
    .load      (accept),
    .loadValue (seed),
    .step      (state == GEN),
    .value     (lfsrValue)
  );

  assign unusedLfsr = ^lfsrValue;
  assign lfsrX = lfsrValue[XW-1:0];
  assign lfsrY = lfsrValue[8+YW-1:8];

  assign accept = (state == IDLE) && start;
  assign numMinesClamp = (numMines > MAX_MINES)
                       ? MAX_MINES : numMines;

  // Out-of-range, safe-cell and already-mined candidates are redrawn.
  assign reject = ({1'b0, lfsrX} >= WIDTH_LIM)
               || ({1'b0, lfsrY} >= HEIGHT_LIM)
               || ((lfsrX == safeXq) && (lfsrY == safeYq))
               || mineReadValue;

  assign lastPlace = (placedCount + CW'(1)) == target;

  assign readX = (state == CHECK) ? lfsrX : candX;
  assign readY = (state == CHECK) ? lfsrY : candY;

  assign placeEn = (state == PLACE);
  assign placeX  = placeEn ? candX : '0;
  assign placeY  = placeEn ? candY : '0;

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:
        if (start)
          stateNext = (numMinesClamp == '0) ? DONE : GEN;
      GEN:     stateNext = CHECK;
      CHECK:   stateNext = reject ? GEN : PLACE;
      PLACE:   stateNext = lastPlace ? DONE : GEN;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk_tb or negedge reset_tb) begin
    if (!reset_tb) begin
      state       <= IDLE;
      target      <= '0;
      safeXq      <= '0;
      safeYq      <= '0;
      candX       <= '0;
      candY       <= '0;
      placedCount <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state <= stateNext;
      done  <= (state == DONE);
      if (accept) begin
        target      <= numMinesClamp;
        safeXq      <= safeX;
        safeYq      <= safeY;
        placedCount <= '0;
        busy        <= 1'b1;
      end
      if (state == CHECK) begin
        candX <= lfsrX;
        candY <= lfsrY;
      end
      if (state == PLACE)
        placedCount <= placedCount + CW'(1);
      if (state == DONE)
        busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mine_placer.sv
// Bench for mine_placer on an 8x8 board with mine and adjacency board models.
// Placements are predicted by a reference model and checked as they appear.
module tb_mine_placer;
  import minesweeper_pkg::*;

  typedef struct {
    logic [15:0] seed;
    int          n;
    int          sx;
    int          sy;
    int          expCount;
    int          expLat;
    int          expBusy;
  } vec_t;

  logic       clk_tb = 1'b0;
  logic       reset_tb = 1'b0;
  logic       start = 1'b0;
  logic [15:0] seed = '0;
  logic [6:0] numMines = '0;
  logic [2:0] safeX = '0, safeY = '0;
  logic [2:0] readX, readY, placeX, placeY;
  logic       mineReadValue, placeEn, busy, done;
  logic [6:0] placedCount;

  logic [63:0] mineB;
  int          adj [64];
  logic [5:0]  expQ [$];
  logic [5:0]  gotQ [$];
  logic [5:0]  seqA [$];

  int passCnt = 0, totalCnt = 0;
  int cyc = 0;
  int pulses = 0, dones = 0, busyCyc = 0;
  vec_t vecs [6];

  always #5 clk_tb = ~clk_tb;

  mine_placer #(.width(8), .height(8)) dut (
    .clk_tb        (clk_tb),
    .reset_tb      (reset_tb),
    .start         (start),
    .seed          (seed),
    .numMines      (numMines),
    .safeX         (safeX),
    .safeY         (safeY),
    .readX         (readX),
    .readY         (readY),
    .mineReadValue (mineReadValue),
    .placeX        (placeX),
    .placeY        (placeY),
    .placeEn       (placeEn),
    .busy          (busy),
    .done          (done),
    .placedCount   (placedCount)
  );

  assign mineReadValue = mineB[{readY, readX}];

  always @(posedge clk_tb) cyc <= cyc + 1;

  // Mine board and adjacency board, wired as at the top level.
  always @(posedge clk_tb or negedge reset_tb) begin
    if (!reset_tb) begin
      mineB <= '0;
      for (int i = 0; i < 64; i++) adj[i] <= 0;
    end else if (placeEn) begin
      mineB[{placeY, placeX}] <= 1'b1;
      for (int dy = -1; dy <= 1; dy++)
        for (int dx = -1; dx <= 1; dx++) begin
          int nx, ny;
          nx = int'(placeX) + dx;
          ny = int'(placeY) + dy;
          if ((dx != 0 || dy != 0) && nx >= 0 && nx < 8
              && ny >= 0 && ny < 8)
            adj[ny*8+nx] <= adj[ny*8+nx] + 1;
        end
    end
  end

  task automatic check(input string name, input longint got,
                       input longint exp);
    totalCnt++;
    if (got == exp) passCnt++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  always @(negedge clk_tb) begin
    if (busy) busyCyc++;
    if (done) dones++;
    if (placeEn) begin
      pulses++;
      gotQ.push_back({placeY, placeX});
      if (expQ.size() == 0) begin
        check("unexpected placeEn", 1, 0);
      end else begin
        logic [5:0] e;
        e = expQ.pop_front();
        check("placeYX", {placeY, placeX}, e);
      end
    end
  end

  function automatic logic [15:0] lfsrStep(input logic [15:0] v);
    logic [15:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  task automatic modelRun(input logic [15:0] s, input int n,
                          input int sx, input int sy);
    logic [15:0] l;
    logic [63:0] m;
    logic [2:0]  cx, cy;
    int tgt, k, guard;
    l = (s == 16'h0000) ? 16'hACE1 : s;
    m = '0;
    tgt = (n > 63) ? 63 : n;
    k = 0;
    guard = 0;
    while (k < tgt && guard < 300000) begin
      l = lfsrStep(l);
      cx = l[2:0];
      cy = l[10:8];
      guard++;
      if (!(int'(cx) == sx && int'(cy) == sy) && !m[{cy, cx}]) begin
        m[{cy, cx}] = 1'b1;
        expQ.push_back({cy, cx});
        k++;
      end
    end
  endtask

  function automatic int adjErrors();
    int errs, cnt, nx, ny;
    errs = 0;
    for (int c = 0; c < 64; c++) begin
      cnt = 0;
      for (int dy = -1; dy <= 1; dy++)
        for (int dx = -1; dx <= 1; dx++) begin
          nx = c % 8 + dx;
          ny = c / 8 + dy;
          if ((dx != 0 || dy != 0) && nx >= 0 && nx < 8
              && ny >= 0 && ny < 8 && mineB[ny*8+nx])
            cnt++;
        end
      if (cnt != adj[c]) errs++;
    end
    return errs;
  endfunction

  task automatic doReset();
    reset_tb = 1'b0;
    start = 1'b0;
    expQ.delete();
    repeat (2) @(posedge clk_tb);
    #1 reset_tb = 1'b1;
  endtask

  task automatic startRun(input logic [15:0] s, input int n,
                          input int sx, input int sy,
                          output int t0);
    @(posedge clk_tb);
    #1;
    pulses = 0;
    dones = 0;
    busyCyc = 0;
    gotQ.delete();
    seed = s;
    numMines = 7'(n);
    safeX = 3'(sx);
    safeY = 3'(sy);
    start = 1'b1;
    t0 = cyc;
    @(posedge clk_tb);
    #1 start = 1'b0;
  endtask

  task automatic waitDone(input int t0, output int lat);
    bit seen;
    seen = 0;
    lat = -1;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk_tb);
      if (done) begin
        seen = 1;
        lat = cyc - t0;
        break;
      end
    end
    if (!seen) check("done timeout", 0, 1);
    repeat (2) @(negedge clk_tb);
  endtask

  task automatic runOne(input vec_t v);
    int t0, lat;
    modelRun(v.seed, v.n, v.sx, v.sy);
    startRun(v.seed, v.n, v.sx, v.sy, t0);
    waitDone(t0, lat);
    check("placedCount", placedCount, v.expCount);
    check("placeEn pulses", pulses, v.expCount);
    check("done pulses", dones, 1);
    check("model leftovers", expQ.size(), 0);
    check("mines on board", $countones(mineB), v.expCount);
    check("safe cell mined", mineB[v.sy*8+v.sx], 0);
    check("adjacency errors", adjErrors(), 0);
    if (v.expLat >= 0) check("done latency", lat, v.expLat);
    if (v.expBusy >= 0) check("busy cycles", busyCyc, v.expBusy);
  endtask

  initial begin
    int t0, lat, diffs, waitCnt;

    vecs[0] = '{16'h0001, 10, 3, 3, 10, -1, -1};
    vecs[1] = '{16'h1234, 0, 5, 5, 0, 2, 1};
    vecs[2] = '{16'hACE1, 100, 0, 0, 63, -1, -1};
    vecs[3] = '{16'h0042, 64, 2, 5, 63, -1, -1};
    vecs[4] = '{16'h5A5A, 1, 7, 7, 1, -1, -1};
    vecs[5] = '{16'h00FF, 63, 7, 0, 63, -1, -1};

    #2;
    check("reset placeEn", placeEn, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset placedCount", placedCount, 0);
    check("reset readXY", {readY, readX}, 0);

    for (int i = 0; i < 6; i++) begin
      doReset();
      runOne(vecs[i]);
    end

    // Second start mid-run must be ignored.
    doReset();
    modelRun(16'h0777, 10, 4, 4);
    startRun(16'h0777, 10, 4, 4, t0);
    repeat (5) @(posedge clk_tb);
    #1;
    seed = 16'h1111;
    numMines = 7'd5;
    safeX = 3'd1;
    safeY = 3'd1;
    start = 1'b1;
    @(posedge clk_tb);
    #1 start = 1'b0;
    waitDone(t0, lat);
    check("repulse placedCount", placedCount, 10);
    check("repulse pulses", pulses, 10);
    check("repulse leftovers", expQ.size(), 0);
    check("repulse safe", mineB[4*8+4], 0);

    // Asynchronous reset while placing.
    doReset();
    modelRun(16'h2222, 20, 0, 7);
    startRun(16'h2222, 20, 0, 7, t0);
    waitCnt = 0;
    while (!placeEn && waitCnt < 1000) begin
      @(negedge clk_tb);
      waitCnt++;
    end
    check("reached PLACE", placeEn, 1);
    #2 reset_tb = 1'b0;
    #1;
    check("abort placeEn", placeEn, 0);
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort placedCount", placedCount, 0);
    expQ.delete();
    @(posedge clk_tb);
    #1 reset_tb = 1'b1;
    runOne(vecs[0]);

    // Same seed after reset reproduces the sequence.
    doReset();
    runOne('{16'hBEEF, 12, 2, 2, 12, -1, -1});
    seqA = gotQ;
    doReset();
    runOne('{16'hBEEF, 12, 2, 2, 12, -1, -1});
    diffs = (gotQ.size() == seqA.size()) ? 0 : 1;
    for (int i = 0; i < gotQ.size() && i < seqA.size(); i++)
      if (gotQ[i] != seqA[i]) diffs++;
    check("BEEF repeat diffs", diffs, 0);

    // Zero seed stands in for the default seed.
    doReset();
    runOne('{16'h0000, 8, 6, 1, 8, -1, -1});
    seqA = gotQ;
    doReset();
    runOne('{16'hACE1, 8, 6, 1, 8, -1, -1});
    diffs = (gotQ.size() == seqA.size()) ? 0 : 1;
    for (int i = 0; i < gotQ.size() && i < seqA.size(); i++)
      if (gotQ[i] != seqA[i]) diffs++;
    check("zero seed diffs", diffs, 0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
